ysyx_22040237_mem_arb: RTL

Two-requester memory arbiter for the RV64 core. It shares one memory port between the instruction fetch path (read-only) and the load/store path (read/write), with one outstanding transaction at a time. Responses are routed back to whichever requester owns the transaction, and a watchdog flags a memory port that never responds. It sits between the fetch/LSU logic and the single memory interface of the core top level.

---
 rtl/ysyx_22040237_mem_arb.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ysyx_22040237_mem_arb.sv
// rtl/ysyx_22040237_mem_arb.sv - fetch/load-store memory arbiter with response watchdog
// Optional macro ARB_RR_EN: round-robin arbitration (default build: fixed priority, LS over IF).
module ysyx_22040237_mem_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_valid,
    input  logic [ADDR_W-1:0]     if_req_addr,
    output logic                  if_req_ready,
    output logic                  if_rsp_valid,
    output logic [DATA_W-1:0]     if_rsp_data,
    input  logic                  ls_req_valid,
    input  logic                  ls_req_wen,
    input  logic [ADDR_W-1:0]     ls_req_addr,
    input  logic [DATA_W-1:0]     ls_req_wdata,
    input  logic [DATA_W/8-1:0]   ls_req_wmask,
    output logic                  ls_req_ready,
    output logic                  ls_rsp_valid,
    output logic [DATA_W-1:0]     ls_rsp_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_wen,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_wmask,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_data,
    output logic                  busy,
    output logic                  timeout_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`ifdef ARB_RR_EN
    logic             last_q;
`endif

    logic grant_vld, grant, grant_if, grant_ls;
    logic hs, rsp_hit, expire;

    always_comb begin
        grant_vld = 1'b0;
        grant     = owner_q;
        case (state_q)
            S_IDLE: begin
                grant_vld = if_req_valid | ls_req_valid;
                if (if_req_valid && ls_req_valid) begin
`ifdef ARB_RR_EN
                    grant = ~last_q;
`else
                    grant = OWN_LS;
`endif
                end else begin
                    grant = ls_req_valid ? OWN_LS : OWN_IF;
                end
            end
            S_HOLD:  grant_vld = 1'b1;
            default: grant_vld = 1'b0;
        endcase
    end

    assign grant_if = grant_vld & (grant == OWN_IF);
    assign grant_ls = grant_vld & (grant == OWN_LS);
    assign hs       = grant_vld & mem_req_ready;

    // Fields are zeroed when nothing is granted so idle outputs never leak requester inputs.
    assign mem_req_valid = grant_vld;
    assign mem_req_wen   = grant_ls & ls_req_wen;
    assign mem_req_addr  = grant_ls ? ls_req_addr : (grant_if ? if_req_addr : '0);
    assign mem_req_wdata = grant_ls ? ls_req_wdata : '0;
    assign mem_req_wmask = grant_ls ? ls_req_wmask : '0;

    assign if_req_ready = mem_req_ready & grant_if;
    assign ls_req_ready = mem_req_ready & grant_ls;

    assign rsp_hit      = (state_q == S_WAIT) & mem_rsp_valid;
    assign if_rsp_valid = rsp_hit & (owner_q == OWN_IF);
    assign ls_rsp_valid = rsp_hit & (owner_q == OWN_LS);
    assign if_rsp_data  = if_rsp_valid ? mem_rsp_data : '0;
    assign ls_rsp_data  = ls_rsp_valid ? mem_rsp_data : '0;

    assign busy        = (state_q != S_IDLE);
    assign timeout_err = err_q;

    // A response in the final wait cycle wins over expiry.
    assign expire = (TIMEOUT != 0) && (state_q == S_WAIT) && !mem_rsp_valid && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    owner_d = grant;
                    state_d = hs ? S_WAIT : S_HOLD;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                if (hs) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (rsp_hit) begin
                    state_d = S_IDLE;
                end else if (expire) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= OWN_IF;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= OWN_IF;
        end else if (hs) begin
            last_q <= grant;
        end
    end
`endif

endmodule
